// File: rtl/cpu_types_pkg.sv
// Types shared by the execute-stage units: multiply/divide opcodes, FSM states
// and the iteration count of the iterative multiplier/divider.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);
endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negator: magnitude of a signed operand on the
// way in, sign restoration of a result on the way out.
module md_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);
    assign y_o = neg_i ? -x_i : x_i;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide with HI/LO result registers, a
// start/busy/done handshake and pipeline flush.
module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             FLUSH,
    input  logic             WRITE_HI,
    input  logic             WRITE_LO,
    input  logic [WIDTH-1:0] WDATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    md_state_t             state_q, state_d;
    logic [MD_CNT_W-1:0]   count_q, count_d;
    md_op_t                op_q, op_d;
    logic                  sign_res_q, sign_res_d;
    logic                  sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0]      opa_q, opa_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]    acc_q, acc_d;      // {product hi, multiplier/product lo} or {-, dividend/quotient}
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic                  done_q, done_d;

    md_op_t                op_in;
    logic                  in_signed, in_div, op_is_div;
    logic [WIDTH-1:0]      mag_a, mag_b;
    logic [WIDTH:0]        add_sum, shifted, diff;
    logic [2*WIDTH-1:0]    prod_fix;
    logic [WIDTH-1:0]      quo_fix, rem_fix;

    assign op_in     = md_op_t'(OP);
    assign in_signed = (op_in == MULT) || (op_in == DIV);
    assign in_div    = (op_in == DIV) || (op_in == DIVU);
    assign op_is_div = (op_q == DIV) || (op_q == DIVU);

    md_abs_neg #(.W(WIDTH)) u_abs_a (.x_i(A), .neg_i(in_signed & A[WIDTH-1]), .y_o(mag_a));
    md_abs_neg #(.W(WIDTH)) u_abs_b (.x_i(B), .neg_i(in_signed & B[WIDTH-1]), .y_o(mag_b));

    // Unsigned ops latch zero signs, so the fixup stage is a no-op for them.
    md_abs_neg #(.W(2*WIDTH)) u_fix_prod (.x_i(acc_q), .neg_i(sign_res_q), .y_o(prod_fix));
    md_abs_neg #(.W(WIDTH)) u_fix_quo (.x_i(acc_q[WIDTH-1:0]), .neg_i(sign_res_q), .y_o(quo_fix));
    md_abs_neg #(.W(WIDTH)) u_fix_rem (.x_i(rem_q), .neg_i(sign_rem_q), .y_o(rem_fix));

    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
    assign shifted = {rem_q, acc_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, opa_q};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        sign_res_d = sign_res_q;
        sign_rem_d = sign_rem_q;
        opa_d      = opa_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        if (WRITE_HI) hi_d = WDATA;
        if (WRITE_LO) lo_d = WDATA;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    op_d       = op_in;
                    opa_d      = in_div ? mag_b : mag_a;
                    acc_d      = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                    rem_d      = '0;
                    // Divide by zero keeps an all-ones quotient whatever the signs.
                    sign_res_d = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]) & ~(in_div & (B == '0));
                    sign_rem_d = in_signed & A[WIDTH-1];
                    count_d    = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (FLUSH) begin
                    state_d = IDLE;
                end else begin
                    if (op_is_div) begin
                        // Restoring step: keep the shifted remainder when the subtract borrows.
                        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                    count_d = count_q + MD_CNT_W'(1);
                    if (count_q == MD_CNT_W'(MD_ITER - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!FLUSH) begin
                    hi_d   = op_is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d   = op_is_div ? quo_fix : prod_fix[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= MULT;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            opa_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            sign_res_q <= sign_res_d;
            sign_rem_q <= sign_rem_d;
            opa_q      <= opa_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multi-cycle multiply/divide unit for the execute stage of the pipelined CPU. It takes the same 32-bit operands the single-cycle ALU sees and computes 64-bit products or quotient/remainder pairs over 34 cycles. Results go into architectural HI/LO registers. A start/busy/done handshake lets the hazard unit stall the pipeline, and a flush input lets it abort an in-flight operation.

## Interface
- Parameters:
- `WIDTH`, default 32: operand width; HI/LO are each `WIDTH` bits.
- Ports:
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `START`  in  1: begin an operation; sampled only in IDLE.
- `OP`  in  2: `md_op_t` value: MULT=00, MULTU=01, DIV=10, DIVU=11.
- `A`  in  32: multiplicand or dividend.
- `B`  in  32: multiplier or divisor.
- `FLUSH`  in  1: abort the in-flight operation.
- `WRITE_HI`  in  1: MTHI strobe.
- `WRITE_LO`  in  1: MTLO strobe.
- `WDATA`  in  32: MTHI/MTLO data.
- `BUSY`  out  1: operation in progress (state != IDLE).
- `DONE`  out  1: registered one-cycle pulse; HI/LO hold the new result.
- `HI`  out  32: product[63:32] or remainder.
- `LO`  out  32: product[31:0] or quotient.

## Operation
- Reset (async, RST=1):
  - state=IDLE, count=0.
  - BUSY=0, DONE=0, HI=0, LO=0.
  - All working registers cleared.
- State machine: IDLE, CALC, FIX.
- IDLE:
  - On START=1, latch OP.
  - For signed ops, latch |A| and |B|, plus sign_res = A[31]^B[31] and sign_rem = A[31].
  - Go to CALC with count=0.
- CALC:
  - One iteration per cycle; count runs 0..31.
  - On count==31, go to FIX.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring division with a 33-bit partial remainder.
- FIX (one cycle):
  - Signed multiply: negate the 64-bit product if sign_res.
  - Signed divide: negate the quotient if sign_res; negate the remainder if sign_rem.
  - Write HI/LO; set DONE for the next cycle; return to IDLE.
- Arithmetic rules:
  - |0x80000000| = 0x80000000, treated as an unsigned 32-bit magnitude.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0), all ops, full normal latency, no exception:
  - DIVU: LO=0xFFFFFFFF, HI=A.
  - DIV: LO=0xFFFFFFFF, HI=A.
- START while BUSY=1 is ignored.
- FLUSH=1 in CALC or FIX:
  - Next state IDLE; HI/LO unchanged; DONE not asserted.
  - FLUSH in IDLE has no effect.
  - FLUSH and START in the same IDLE cycle: START is accepted.
- WRITE_HI/WRITE_LO:
  - Take effect at the next edge in any state.
  - If asserted on the same edge as the FIX write, the FIX result wins.
- DONE and a new START in the same cycle is legal; the new op is accepted.

## Timing
- Edge 0: START sampled in IDLE.
- Edges 1–32: CALC iterations.
- Edge 33: FIX writes HI/LO and sets DONE=1.
- DONE is high between edge 33 and edge 34.
- Total latency: 34 cycles from START to DONE.
- BUSY is high from after edge 0 until edge 33.
- Back-to-back ops: throughput of 1 op per 34 cycles.
- HI/LO change only at the FIX edge or on MT strobes.
- The hazard unit stalls MFHI/MFLO while BUSY=1.

## Structure
- Shared in `cpu_types_pkg`:
  - `md_op_t` enum (MULT, MULTU, DIV, DIVU).
  - `md_state_t` enum (IDLE, CALC, FIX).
  - `MD_ITER = 32`.
- One sub-module: `md_abs_neg`, a combinational conditional two's-complement negator.
  - Used for operand magnitudes in IDLE and for result fixup in FIX.
- Everything else lives in one `always_ff` block for state/count/datapath and one `always_comb` block for next state.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001; DONE high exactly 34 cycles after START; BUSY high for 33 cycles.
- MULT A=0xFFFFFFFD (−3), B=5: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0: LO=0xFFFFFFFF, HI=100. Then DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Preload with WRITE_HI=0x1234. Start MULTU 3×4. FLUSH at cycle 10: HI=0x1234, no DONE, BUSY=0 next cycle. A START pulsed while BUSY is ignored.
- Assert RST mid-CALC: outputs clear immediately (async), with no clock edge needed.
